path_replay: RTL and testbench

- Downstream consumer of the 2-bit direction stack: once the maze solver finishes, this block drains the stack one move at a time.
- Each popped move is undone against a running coordinate, starting from the goal cell. The emitted positions trace the solved path from goal back to start.
- Each step is presented on a valid/ready output port to the display/result stage, with a final step count and done pulse.

---
 rtl/maze_pkg.sv | 32 +++
 rtl/move_undo.sv | 47 ++++
 rtl/path_replay.sv | 139 +++++++++++++
 tb/tb_path_replay.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// =============================================================================
// maze_pkg : direction codes, replay state encoding and shared maze sizes
// Rev 1.0
// =============================================================================
`default_nettype none

package maze_pkg;

    localparam int MAZE_DIR_W      = 2;
    localparam int COORD_W_DEFAULT = 4;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } replay_state_t;

    // The code set is chosen so that bitwise inversion yields the opposite move.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return ~d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/move_undo.sv
// =============================================================================
// move_undo : applies one move (or its inverse) to an X/Y coordinate, modulo 2**COORD_W
// Rev 1.0
// =============================================================================
`default_nettype none

module move_undo
    import maze_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int DIR_W   = MAZE_DIR_W,
    parameter bit UNDO    = 1'b1
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [DIR_W-1:0]   dir,
    output logic [COORD_W-1:0] new_x,
    output logic [COORD_W-1:0] new_y,
    output logic               wrap
);

    localparam logic [COORD_W:0] C_ONE = {{COORD_W{1'b0}}, 1'b1};

    logic [1:0]       eff_dir;
    logic [COORD_W:0] ext_x;
    logic [COORD_W:0] ext_y;

    // The extra MSB of each extended coordinate captures carry or borrow.
    always_comb begin
        eff_dir = UNDO ? dir_opposite(dir[1:0]) : dir[1:0];
        ext_x   = {1'b0, x};
        ext_y   = {1'b0, y};
        case (eff_dir)
            DIR_UP:    ext_y = {1'b0, y} - C_ONE;
            DIR_RIGHT: ext_x = {1'b0, x} + C_ONE;
            DIR_LEFT:  ext_x = {1'b0, x} - C_ONE;
            DIR_DOWN:  ext_y = {1'b0, y} + C_ONE;
            default:   ext_x = {1'b0, x};
        endcase
        new_x = ext_x[COORD_W-1:0];
        new_y = ext_y[COORD_W-1:0];
        wrap  = ext_x[COORD_W] | ext_y[COORD_W];
    end

endmodule

`default_nettype wire

// File: rtl/path_replay.sv
// =============================================================================
// path_replay : drains the direction stack, undoing each move from the goal cell
// Rev 1.0
// =============================================================================
`default_nettype none

module path_replay
    import maze_pkg::*;
#(
    parameter int DIR_W   = MAZE_DIR_W,
    parameter int PTR_W   = 8,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    input  logic               stk_empty,
    input  logic [DIR_W-1:0]   stk_data,
    output logic               stk_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [DIR_W-1:0]   out_dir,
    output logic [PTR_W:0]     step_count,
    output logic               busy,
    output logic               done,
    output logic               wrap_err
);

    localparam logic [PTR_W:0] C_STEP_ONE = {{PTR_W{1'b0}}, 1'b1};

    replay_state_t state;
    replay_state_t state_nx;

    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [COORD_W-1:0] undo_x;
    logic [COORD_W-1:0] undo_y;
    logic               undo_wrap;
    logic [DIR_W-1:0]   dir_q;
    logic [PTR_W:0]     steps;
    logic               wrap_q;

    move_undo #(
        .COORD_W (COORD_W),
        .DIR_W   (DIR_W),
        .UNDO    (1'b1)
    ) u_move_undo (
        .x     (pos_x),
        .y     (pos_y),
        .dir   (stk_data),
        .new_x (undo_x),
        .new_y (undo_y),
        .wrap  (undo_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // stk_empty in EMIT already reflects the pop issued for the step on display.
    always_comb begin
        state_nx  = state;
        stk_pop   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = stk_empty ? ST_DONE : ST_POP;
                end
            end
            ST_POP: begin
                stk_pop  = !stk_empty;
                state_nx = stk_empty ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                state_nx = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = stk_empty ? ST_DONE : ST_POP;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x  <= '0;
            pos_y  <= '0;
            dir_q  <= '0;
            steps  <= '0;
            wrap_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                pos_x  <= goal_x;
                pos_y  <= goal_y;
                steps  <= '0;
                wrap_q <= 1'b0;
            end
            if (state == ST_WAIT) begin
                pos_x  <= undo_x;
                pos_y  <= undo_y;
                dir_q  <= stk_data;
                wrap_q <= wrap_q | undo_wrap;
            end
            if (state == ST_EMIT && out_ready) begin
                steps <= steps + C_STEP_ONE;
            end
        end
    end

    assign out_x      = pos_x;
    assign out_y      = pos_y;
    assign out_dir    = dir_q;
    assign step_count = steps;
    assign wrap_err   = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_path_replay.sv
// =============================================================================
// tb_path_replay : randomized self-checking bench with a behavioural stack and path model
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_path_replay;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] goal_x;
    logic [3:0] goal_y;
    logic       stk_empty;
    logic [1:0] stk_data;
    logic       stk_pop;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic [1:0] out_dir;
    logic [8:0] step_count;
    logic       busy;
    logic       done;
    logic       wrap_err;

    int n_checks = 0;
    int n_errors = 0;

    path_replay #(
        .DIR_W   (2),
        .PTR_W   (8),
        .COORD_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .goal_x     (goal_x),
        .goal_y     (goal_y),
        .stk_empty  (stk_empty),
        .stk_data   (stk_data),
        .stk_pop    (stk_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_dir    (out_dir),
        .step_count (step_count),
        .busy       (busy),
        .done       (done),
        .wrap_err   (wrap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LIFO with registered read data, independent of DUT reset.
    logic [1:0] stk_mem [256];
    int         sp = 0;
    logic       push_en;
    logic [1:0] push_d;
    int         model_q[$];

    assign stk_empty = (sp == 0);

    always @(posedge clk) begin
        if (push_en) begin
            stk_mem[sp] <= push_d;
            sp          <= sp + 1;
        end else if (stk_pop && sp != 0) begin
            stk_data <= stk_mem[sp - 1];
            sp       <= sp - 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int d);
        push_en = 1'b1;
        push_d  = d[1:0];
        @(posedge clk); #1;
        push_en = 1'b0;
        model_q.push_back(d & 3);
    endtask

    // mode 0: ready tied high, 1: random ready, 2: ready low for the first 4 EMIT cycles
    task automatic run_replay(input int gx, input int gy, input int mode, input bit stray);
        int  n, x, y, c, pops, dones, done_c, first_v, viol, hx, hy, hd;
        int  ex[$], ey[$], ed[$], gxq[$], gyq[$], gdq[$];
        bit  wrap_exp, fin, hold;
        n = model_q.size();
        x = gx; y = gy; wrap_exp = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            case (model_q[i])
                0:       y = y + 1;
                1:       x = x - 1;
                2:       x = x + 1;
                default: y = y - 1;
            endcase
            if (x < 0 || x > 15 || y < 0 || y > 15) wrap_exp = 1'b1;
            x = (x + 16) % 16;
            y = (y + 16) % 16;
            ex.push_back(x); ey.push_back(y); ed.push_back(model_q[i]);
        end

        goal_x    = gx[3:0];
        goal_y    = gy[3:0];
        start     = 1'b1;
        out_ready = (mode != 2);
        @(posedge clk); #1;
        start = 1'b0;

        pops = 0; dones = 0; done_c = -1; first_v = -1; viol = 0;
        fin = 1'b0; hold = 1'b0; hx = 0; hy = 0; hd = 0;
        for (c = 1; c <= 4000 && !fin; c++) begin
            @(negedge clk);
            if (c == 1) check("wrap_clear_on_start", int'(wrap_err), 0);
            if (stk_pop) begin
                pops++;
                if (stk_empty) viol++;
            end
            if (out_valid && first_v < 0) first_v = c;
            if (hold && (!out_valid || int'(out_x) != hx || int'(out_y) != hy || int'(out_dir) != hd))
                viol++;
            if (int'(step_count) != gxq.size()) viol++;
            if (out_valid && out_ready) begin
                gxq.push_back(int'(out_x)); gyq.push_back(int'(out_y)); gdq.push_back(int'(out_dir));
            end
            hold = out_valid && !out_ready;
            hx = int'(out_x); hy = int'(out_y); hd = int'(out_dir);
            if (done) begin
                dones++;
                done_c = c;
                fin    = 1'b1;
            end
            @(posedge clk); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (c + 1 >= 7);
            endcase
            start = stray && busy && !done && ($urandom_range(0, 3) == 0);
            if (start) begin
                goal_x = 4'($urandom_range(0, 15));
                goal_y = 4'($urandom_range(0, 15));
            end
        end
        start = 1'b0;

        if (!fin) check("timeout", 0, 1);
        check("pop_count", pops, n);
        check("steps_seen", gxq.size(), n);
        for (int i = 0; i < n && i < gxq.size(); i++) begin
            check("out_x", gxq[i], ex[i]);
            check("out_y", gyq[i], ey[i]);
            check("out_dir", gdq[i], ed[i]);
        end
        check("step_count", int'(step_count), n);
        check("done_pulses", dones, 1);
        check("done_width", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("wrap_err", int'(wrap_err), int'(wrap_exp));
        check("protocol", viol, 0);
        if (n == 0) begin
            check("no_valid", first_v, -1);
            check("empty_done_lat", done_c, 1);
        end else begin
            check("first_latency", first_v, 3);
        end
        model_q.delete();
    endtask

    task automatic reset_test();
        int hs, c, dones;
        for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 3)));
        goal_x    = 4'($urandom_range(2, 13));
        goal_y    = 4'($urandom_range(2, 13));
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (hs == 1 && out_valid && !out_ready) break;
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
            if (hs >= 1) out_ready = 1'b0;
        end
        check("rst_reach_emit2", int'(hs == 1 && out_valid && !out_ready), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_stk_pop", int'(stk_pop), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_count", int'(step_count), 0);
        check("rst_out_xy", int'(out_x) + int'(out_y), 0);
        check("rst_wrap_err", int'(wrap_err), 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        if (done) dones++;
        check("rst_no_done", dones, 0);
        check("rst_stack_left", sp, 2);
        @(posedge clk); #1;
        void'(model_q.pop_back());
        void'(model_q.pop_back());
        run_replay(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        goal_x    = '0;
        goal_y    = '0;
        out_ready = 1'b0;
        push_en   = 1'b0;
        push_d    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_stk_pop", int'(stk_pop), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_step_count", int'(step_count), 0);
        check("reset_wrap_err", int'(wrap_err), 0);
        check("reset_out_x", int'(out_x), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        push(1); push(1); push(3);
        run_replay(2, 1, 0, 1'b0);

        run_replay(4, 4, 0, 1'b0);

        push(2);
        run_replay(5, 5, 2, 1'b0);

        push(0);
        run_replay(3, 15, 0, 1'b0);
        push(1);
        run_replay(7, 7, 0, 1'b0);

        for (int i = 0; i < 6; i++) push(int'($urandom_range(0, 3)));
        run_replay(8, 8, 0, 1'b1);

        reset_test();

        for (int t = 0; t < 15; t++) begin
            int n;
            n = int'($urandom_range(0, 24));
            for (int i = 0; i < n; i++) push(int'($urandom_range(0, 3)));
            run_replay(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1,
                       1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 256; i++) push(int'($urandom_range(0, 3)));
        run_replay(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
